ecc_decoder: RTL and testbench
==============================

// Module: ecc_decoder
// PURPOSE
//  SECDED decoder paired with the extended-Hamming encoder. Takes a codeword (8/16/32-bit frame, 4/11/26 info bits),
//  recomputes syndrome + overall parity, corrects 1-bit errors, flags 2-bit errors. 2-stage valid/ready pipeline.
//  Sits between the channel/register path and the data consumer.
// PARAMETERS
//  DATA_WIDTH  32  max codeword frame width: 8, 16 or 32; other values illegal (elaboration error)
//  AMBA_WORD   32  width of the CODEWORD_WIDTH mode input
// PORTS
//  clk             in   1           single clock, rising edge
//  rst             in   1           asynchronous, active-low reset
//  in_valid        in   1           codeword_in/CODEWORD_WIDTH valid
//  in_ready        out  1           decoder accepts this cycle; transfer = in_valid & in_ready
//  codeword_in     in   DATA_WIDTH  {info, C_overall, C_hamming MSB..LSB}, right-aligned, upper bits ignored
//  CODEWORD_WIDTH  in   AMBA_WORD   0: 8-bit frame, 1: 16-bit, >=2: 32-bit; clamped to the max DATA_WIDTH allows
//  out_valid       out  1           data_out/num_of_errors valid
//  out_ready       in   1           consumer accepts; transfer = out_valid & out_ready
//  data_out        out  DATA_WIDTH  corrected info, right-aligned, zero-padded
//  num_of_errors   out  2           0 none, 1 corrected, 2 uncorrectable
// BEHAVIOUR
//  Reset (rst=0, async): stage valids=0, out_valid=0, data_out=0, num_of_errors=0; in_ready=1 after release.
//  Layout per mode: K info bits, R Hamming bits, 1 overall bit; (K,R) = (4,3),(11,4),(26,5).
//   frame = {info[K-1:0], P, C[R-1:0]}; C[R-1] = row 1 of H, C[0] = row R; P = XOR(info,C).
//  Stage 1 (on input transfer): register active-width slice, mode, syndrome S[i] = XOR(info & H_row_i) ^ C[i],
//   and overall parity Q = XOR of all active frame bits.
//  Stage 2 (on advance): classify and correct:
//   S==0,Q==0 -> errors 0, info unchanged
//   S==0,Q==1 -> errors 1 (P bit flipped), info unchanged
//   S!=0,Q==1 -> errors 1; if S matches an info column of H, flip that info bit; else (unit column) info unchanged
//   S!=0,Q==0 -> errors 2, data_out = uncorrected info (no flip)
//   S!=0,Q==1 with S matching no column (>=3 errors aliasing) -> errors 2
//  Latency: 2 cycles input transfer -> out_valid, no stalls. Throughput 1/cycle with out_ready=1.
//  Backpressure: stage2 holds while out_valid & !out_ready (outputs stable). Stage1 advances when stage2 empty
//   or draining. in_ready = !s1_valid | s1_advance (combinational from out_ready; no bubble on full pipe).
//  Simultaneous in & out transfer on full pipe: both occur, no data lost or duplicated.
//  Mode captured with each codeword; changing CODEWORD_WIDTH never affects words in flight.
//  DATA_WIDTH=8: mode ignored; DATA_WIDTH=16: mode>=1 treated as 1.
//  Reset mid-operation: in-flight words discarded, no partial output.
// STRUCTURE
//  ecc_pkg: H row constants H1_1..H1_3, H2_1..H2_4, H3_1..H3_5 (shared with the encoder), (K,R) per mode,
//   num_of_errors encodings (NO_ERR=0, ONE_ERR=1, TWO_ERR=2).
//  Sub-module ecc_syndrome (combinational): frame + mode -> S, Q; instanced in stage 1.
//  Top: two valid/data pipeline registers, correction/classify logic, handshake.
// TESTING
//  1 mode0, codeword_in=8'hB1 (info 4'hB) -> 2 cycles later data_out=32'hB, num_of_errors=0.
//  2 mode0, 8'h31 (info[3] flipped) -> data_out=4'hB, errors=1; 8'hB9 (P flipped) -> 4'hB, errors=1;
//    8'hB0 (C8 flipped) -> 4'hB, errors=1.
//  3 mode0, 8'h71 (bits 7,6 flipped) -> errors=2, data_out=4'h7 (uncorrected).
//  4 mode1 16'h8000 -> data_out=0, errors=1; mode2 32'h8000_0001 -> errors=2; mode 5 behaves as mode2.
//  5 back-to-back 8 words, out_ready toggled 1/0 randomly -> outputs in order, no drop/dup, held stable on stall.
//  6 rst asserted with 2 words in flight -> out_valid=0 immediately; post-release next word decodes correctly.
//  Plus: random info per mode through encoder model, 0/1/2 random flips -> errors count and data check.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED constants: H-matrix rows, frame layouts and error codes.
// Info column j is the j-th smallest R-bit value of weight >= 2.
package ecc_pkg;

  typedef enum logic [1:0] {
    M8  = 2'd0,
    M16 = 2'd1,
    M32 = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    NO_ERR  = 2'd0,
    ONE_ERR = 2'd1,
    TWO_ERR = 2'd2
  } err_t;

  localparam int K8  = 4;
  localparam int R8  = 3;
  localparam int K16 = 11;
  localparam int R16 = 4;
  localparam int K32 = 26;
  localparam int R32 = 5;

  typedef logic [25:0][4:0] col_tbl_t;

  function automatic col_tbl_t make_cols(input int r);
    col_tbl_t t;
    int j;
    t = '0;
    j = 0;
    for (int v = 1; v < 32; v++) begin
      if (v < (1 << r) && $countones(v) >= 2) begin
        t[j] = 5'(v);
        j++;
      end
    end
    return t;
  endfunction

  // Row i of H is bit R-i of every info column.
  function automatic logic [25:0] h_row(
    input col_tbl_t t,
    input int       r,
    input int       i
  );
    logic [25:0] row;
    row = '0;
    for (int j = 0; j < 26; j++) begin
      row[j] = t[j][r-i];
    end
    return row;
  endfunction

  localparam col_tbl_t COL8  = make_cols(R8);
  localparam col_tbl_t COL16 = make_cols(R16);
  localparam col_tbl_t COL32 = make_cols(R32);

  localparam logic [3:0] H1_1 = 4'(h_row(COL8, R8, 1));
  localparam logic [3:0] H1_2 = 4'(h_row(COL8, R8, 2));
  localparam logic [3:0] H1_3 = 4'(h_row(COL8, R8, 3));

  localparam logic [10:0] H2_1 = 11'(h_row(COL16, R16, 1));
  localparam logic [10:0] H2_2 = 11'(h_row(COL16, R16, 2));
  localparam logic [10:0] H2_3 = 11'(h_row(COL16, R16, 3));
  localparam logic [10:0] H2_4 = 11'(h_row(COL16, R16, 4));

  localparam logic [25:0] H3_1 = h_row(COL32, R32, 1);
  localparam logic [25:0] H3_2 = h_row(COL32, R32, 2);
  localparam logic [25:0] H3_3 = h_row(COL32, R32, 3);
  localparam logic [25:0] H3_4 = h_row(COL32, R32, 4);
  localparam logic [25:0] H3_5 = h_row(COL32, R32, 5);

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome and overall parity of one frame in a given mode.
// Bits above the active frame width are never looked at.
module ecc_syndrome
  import ecc_pkg::*;
(
  input  logic [31:0] frame_i,
  input  mode_t       mode_i,
  output logic [4:0]  syn_o,
  output logic        par_o
);

  logic [3:0]  i8;
  logic [2:0]  c8;
  logic [10:0] i16;
  logic [3:0]  c16;
  logic [25:0] i32;
  logic [4:0]  c32;
  logic [2:0]  s8;
  logic [3:0]  s16;
  logic [4:0]  s32;

  assign i8  = frame_i[7:4];
  assign c8  = frame_i[2:0];
  assign i16 = frame_i[15:5];
  assign c16 = frame_i[3:0];
  assign i32 = frame_i[31:6];
  assign c32 = frame_i[4:0];

  assign s8 = {
    ^(i8 & H1_1) ^ c8[2],
    ^(i8 & H1_2) ^ c8[1],
    ^(i8 & H1_3) ^ c8[0]
  };

  assign s16 = {
    ^(i16 & H2_1) ^ c16[3],
    ^(i16 & H2_2) ^ c16[2],
    ^(i16 & H2_3) ^ c16[1],
    ^(i16 & H2_4) ^ c16[0]
  };

  assign s32 = {
    ^(i32 & H3_1) ^ c32[4],
    ^(i32 & H3_2) ^ c32[3],
    ^(i32 & H3_3) ^ c32[2],
    ^(i32 & H3_4) ^ c32[1],
    ^(i32 & H3_5) ^ c32[0]
  };

  always_comb begin
    syn_o = s32;
    par_o = ^frame_i;
    unique case (mode_i)
      M8: begin
        syn_o = {2'b00, s8};
        par_o = ^frame_i[7:0];
      end
      M16: begin
        syn_o = {1'b0, s16};
        par_o = ^frame_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ecc_decoder.sv
// Two-stage SECDED decoder: stage 1 computes syndrome/parity,
// stage 2 classifies and corrects; valid/ready on both sides.
module ecc_decoder
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AMBA_WORD  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] codeword_in,
  input  logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors
);

  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32)
  begin : g_bad_width
    $error("ecc_decoder: DATA_WIDTH must be 8, 16 or 32");
  end

  logic [31:0]           frame_w;
  logic [31:0]           mask_w;
  logic [31:0]           act_w;
  mode_t                 mode_w;
  logic [4:0]            syn_w;
  logic                  par_w;

  logic                  s1_valid_q, s1_valid_d;
  logic [31:0]           s1_frame_q, s1_frame_d;
  mode_t                 s1_mode_q, s1_mode_d;
  logic [4:0]            s1_syn_q, s1_syn_d;
  logic                  s1_par_q, s1_par_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  err_t                  s2_err_q, s2_err_d;

  logic                  s2_free;
  logic                  s1_adv;
  logic                  in_fire;

  col_tbl_t              cols_w;
  logic [25:0]           info_w;
  logic [25:0]           fix_w;
  logic [25:0]           corr_w;
  logic [31:0]           data32_w;
  logic                  unit_w;
  logic                  flip_w;
  err_t                  err_w;

  assign frame_w = 32'(codeword_in);

  // Mode is clamped to what this frame width can carry.
  always_comb begin
    mode_w = M8;
    if (DATA_WIDTH >= 16 && CODEWORD_WIDTH != '0) begin
      mode_w = M16;
    end
    if (DATA_WIDTH >= 32 && CODEWORD_WIDTH > AMBA_WORD'(1)) begin
      mode_w = M32;
    end
  end

  always_comb begin
    mask_w = 32'hFFFF_FFFF;
    unique case (mode_w)
      M8:      mask_w = 32'h0000_00FF;
      M16:     mask_w = 32'h0000_FFFF;
      default: ;
    endcase
  end

  assign act_w = frame_w & mask_w;

  ecc_syndrome u_syn (
    .frame_i (act_w),
    .mode_i  (mode_w),
    .syn_o   (syn_w),
    .par_o   (par_w)
  );

  assign s2_free  = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    cols_w = COL32;
    info_w = s1_frame_q[31:6];
    unique case (s1_mode_q)
      M8: begin
        cols_w = COL8;
        info_w = {22'b0, s1_frame_q[7:4]};
      end
      M16: begin
        cols_w = COL16;
        info_w = {15'b0, s1_frame_q[15:5]};
      end
      default: ;
    endcase
  end

  // Unused table entries are zero and can only match a zero syndrome.
  always_comb begin
    fix_w = '0;
    for (int j = 0; j < 26; j++) begin
      fix_w[j] = (s1_syn_q == cols_w[j]);
    end
  end

  assign unit_w = (s1_syn_q != '0) &&
                  ((s1_syn_q & (s1_syn_q - 5'd1)) == '0);

  always_comb begin
    err_w  = NO_ERR;
    flip_w = 1'b0;
    if (s1_syn_q == '0) begin
      err_w = s1_par_q ? ONE_ERR : NO_ERR;
    end else if (!s1_par_q) begin
      err_w = TWO_ERR;
    end else if (|fix_w) begin
      err_w  = ONE_ERR;
      flip_w = 1'b1;
    end else if (unit_w) begin
      err_w = ONE_ERR;
    end else begin
      err_w = TWO_ERR;
    end
  end

  assign corr_w   = flip_w ? (info_w ^ fix_w) : info_w;
  assign data32_w = {6'b0, corr_w};

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_frame_d = s1_frame_q;
    s1_mode_d  = s1_mode_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_frame_d = act_w;
      s1_mode_d  = mode_w;
      s1_syn_d   = syn_w;
      s1_par_d   = par_w;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_err_d   = s2_err_q;
    if (s2_free) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      s2_data_d = data32_w[DATA_WIDTH-1:0];
      s2_err_d  = err_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_frame_q <= '0;
      s1_mode_q  <= M8;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= NO_ERR;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_frame_q <= s1_frame_d;
      s1_mode_q  <= s1_mode_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_err_q   <= s2_err_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign data_out      = s2_data_q;
  assign num_of_errors = s2_err_q;

endmodule

// File: tb/tb_ecc_decoder.sv
// Randomised SECDED decoder bench with an extended-Hamming reference
// encoder, an ordered expectation queue and directed vectors.
module tb_ecc_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] codeword_in = '0;
  logic [31:0] CODEWORD_WIDTH = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;

  ecc_decoder #(.DATA_WIDTH(32), .AMBA_WORD(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .codeword_in    (codeword_in),
    .CODEWORD_WIDTH (CODEWORD_WIDTH),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .data_out       (data_out),
    .num_of_errors  (num_of_errors)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: always ready, 1: random, 2: never ready
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom % 2);
    else out_ready = 1'b0;
  end

  typedef struct {
    logic [31:0] d;
    logic [1:0]  e;
    int          c;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void check(input string name,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic int kof(input int e);
    return (e == 0) ? 4 : (e == 1) ? 11 : 26;
  endfunction

  function automatic int rof(input int e);
    return (e == 0) ? 3 : (e == 1) ? 4 : 5;
  endfunction

  // j-th smallest r-bit value with at least two ones
  function automatic logic [4:0] col(input int r, input int j);
    int n;
    n = 0;
    for (int v = 1; v < (1 << r); v++) begin
      if ($countones(v) >= 2) begin
        if (n == j) return 5'(v);
        n++;
      end
    end
    return 5'd0;
  endfunction

  function automatic logic [31:0] encode(input int e,
                                         input logic [31:0] info);
    int k;
    int r;
    logic [4:0] c;
    logic p;
    k = kof(e);
    r = rof(e);
    c = '0;
    for (int j = 0; j < k; j++) begin
      if (info[j]) c = c ^ col(r, j);
    end
    p = (^info) ^ (^c);
    return (info << (r + 1)) | (32'(p) << r) | 32'(c);
  endfunction

  task automatic send(input logic [31:0] f, input logic [31:0] m,
                      input logic [31:0] ed, input logic [1:0] ee);
    bit done;
    int t;
    exp_t x;
    done = 0;
    t = 0;
    codeword_in = f;
    CODEWORD_WIDTH = m;
    in_valid = 1'b1;
    while (!done && t < 200) begin
      @(negedge clk);
      if (in_ready) begin
        x.d = ed;
        x.e = ee;
        x.c = cyc;
        x.lat = (ready_mode == 0);
        exp_q.push_back(x);
        done = 1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never seen, cw=%h", f);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words outstanding, expected 0",
               exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit pv, pr, have;
    logic [31:0] pd;
    logic [1:0] pe;
    exp_t x;
    have = 0;
    pv = 0;
    pr = 0;
    pd = '0;
    pe = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have = 0;
      end else begin
        if (have && pv && !pr) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", data_out, pd);
          check("hold_err", 32'(num_of_errors), 32'(pe));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL extra_output: got %h/%0d, expected none",
                     data_out, num_of_errors);
          end else begin
            x = exp_q.pop_front();
            check("data_out", data_out, x.d);
            check("num_of_errors", 32'(num_of_errors), 32'(x.e));
            if (x.lat) check("latency", 32'(cyc), 32'(x.c + 2));
          end
        end
        pv = out_valid;
        pr = out_ready;
        pd = data_out;
        pe = num_of_errors;
        have = 1;
      end
    end
  endtask

  task automatic rand_word();
    int m, e, k, r, n, nb, p1, p2, w;
    logic [31:0] info, f, kmask;
    m = $urandom_range(0, 3);
    if (m == 3) m = $urandom_range(3, 1000);
    e = (m > 2) ? 2 : m;
    k = kof(e);
    r = rof(e);
    nb = k + r + 1;
    w = (e == 0) ? 8 : (e == 1) ? 16 : 32;
    kmask = (32'd1 << k) - 32'd1;
    info = $urandom & kmask;
    f = encode(e, info);
    n = $urandom_range(0, 2);
    p1 = $urandom_range(0, nb - 1);
    p2 = (p1 + 1 + $urandom_range(0, nb - 2)) % nb;
    if (n >= 1) f[p1] = ~f[p1];
    if (n == 2) f[p2] = ~f[p2];
    if (n == 2) begin
      send(f | ((w < 32) ? ($urandom << w) : 32'd0), 32'(m),
           (f >> (r + 1)) & kmask, 2'd2);
    end else begin
      send(f | ((w < 32) ? ($urandom << w) : 32'd0), 32'(m),
           info, 2'(n));
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_errors", 32'(num_of_errors), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    check("model_enc_m0", encode(0, 32'hB), 32'hB1);
    check("model_enc_m1", encode(1, 32'h400), 32'h801F);

    send(32'hB1, 32'd0, 32'hB, 2'd0);
    send(32'h31, 32'd0, 32'hB, 2'd1);
    send(32'hB9, 32'd0, 32'hB, 2'd1);
    send(32'hB0, 32'd0, 32'hB, 2'd1);
    send(32'h71, 32'd0, 32'h7, 2'd2);
    send(32'h8000, 32'd1, 32'h0, 2'd1);
    send(32'h8000_0001, 32'd2, 32'h200_0000, 2'd2);
    send(32'h8000_0001, 32'd5, 32'h200_0000, 2'd2);
    send(32'hABCD_12B1, 32'd0, 32'hB, 2'd0);
    drain();

    for (int i = 0; i < 40; i++) rand_word();
    drain();

    ready_mode = 1;
    for (int i = 0; i < 300; i++) rand_word();
    drain();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    ready_mode = 2;
    @(posedge clk);
    #1;
    send(32'hB1, 32'd0, 32'hB, 2'd0);
    send(32'h8000, 32'd1, 32'h0, 2'd1);
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
    @(posedge clk);
    #1;
    send(32'h31, 32'd0, 32'hB, 2'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
